// File: rtl/alu_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_param
// Summary  : Registered ALU with a valid/ready handshake on both sides. Holds
//            one operation in flight and a one-entry result register with
//            zero/negative/carry/overflow flags.
// Config   : ALU_MUL_EN -- when defined, op 10 runs an iterative shift-add
//            multiplier (WIDTH steps in a BUSY state). When undefined, op 10
//            is treated as reserved and busy is tied low.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             neg_f,
  output logic             carry_f,
  output logic             ovf_f,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd11;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  logic             accept;
  logic             idle;
  logic             load;
  logic [WIDTH-1:0] load_res;
  logic             load_c;
  logic             load_v;

  // Single-cycle operations; carry/overflow only meaningful for ADD/SUB
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    // The extra top bit of the widened difference is the unsigned borrow
    sub_full = {1'b0, a} - {1'b0, b};
    shamt    = b[SHW-1:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
  end

  // A new request may land in the same cycle the held result is consumed
  assign in_ready = idle && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic             start_mul;
  logic             mul_done;

  assign idle      = (state_q == S_IDLE);
  assign busy      = !idle;
  assign start_mul = accept && (op == OP_MUL);
  assign mul_done  = (state_q == S_BUSY) && (cnt == SHW'(WIDTH - 1));
  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign load      = (accept && !start_mul) || mul_done;
  assign load_res  = mul_done ? acc_step : alu_res;
  assign load_c    = mul_done ? 1'b0 : alu_c;
  assign load_v    = mul_done ? 1'b0 : alu_v;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: IDLE until a MUL is accepted, BUSY for WIDTH steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul) state_d = S_BUSY;
      S_BUSY:  if (mul_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add multiplier: one multiplier bit consumed per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start_mul) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (state_q == S_BUSY) begin
      cnt    <= cnt + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_step;
    end
  end
`else
  assign idle     = 1'b1;
  assign busy     = 1'b0;
  assign load     = accept;
  assign load_res = alu_res;
  assign load_c   = alu_c;
  assign load_v   = alu_v;
`endif

  // One-entry result register; flags derived from the value being loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero_f    <= 1'b1;
      neg_f     <= 1'b0;
      carry_f   <= 1'b0;
      ovf_f     <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_res;
      zero_f    <= (load_res == '0);
      neg_f     <= load_res[WIDTH-1];
      carry_f   <= load_c;
      ovf_f     <= load_v;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_param
// Summary  : Scoreboard bench for alu_seq_param (WIDTH=32). Expected results
//            are pushed when a request is accepted and compared while the
//            DUT presents them.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_param;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero_f;
  logic         neg_f;
  logic         carry_f;
  logic         ovf_f;
  logic         busy;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;   // {zero, neg, carry, ovf}
    bit           mul;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  bit  prev_valid = 1'b0;
  bit  prev_pop = 1'b0;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_f    (zero_f),
    .neg_f     (neg_f),
    .carry_f   (carry_f),
    .ovf_f     (ovf_f),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against the expected one
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, written independently of the RTL datapath
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   r;
    longint sx, sy, s;
    logic [63:0] p;
    int     sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    r.res = '0;
    r.mul = 1'b0;
    r.acc_cyc = 0;
    r.flags = 4'b0;
    case (o)
      4'd0: begin
        r.res = x + y;
        s = sx + sy;
        r.flags[1] = ({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF;
        r.flags[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r.res = x - y;
        s = sx - sy;
        r.flags[1] = (x < y);
        r.flags[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r.res = x & y;
      4'd3:  r.res = x | y;
      4'd4:  r.res = x ^ y;
      4'd5:  r.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd6:  r.res = x << sh;
      4'd7:  r.res = x >> sh;
      4'd8: begin
        for (int i = 0; i < W; i++)
          r.res[i] = (i + sh < W) ? x[i + sh] : x[W-1];
      end
      4'd9:  r.res = (x < y) ? 32'd1 : 32'd0;
      4'd10: begin
        if (MUL_EN) begin
          p = {32'd0, x} * {32'd0, y};
          r.res = p[W-1:0];
          r.mul = 1'b1;
        end
      end
      4'd11: r.res = ~(x | y);
      default: r.res = '0;
    endcase
    r.flags[3] = (r.res == '0);
    r.flags[2] = r.res[W-1];
    return r;
  endfunction

  // Present one request, wait (bounded) for acceptance, record the expectation
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    bit   got;
    got = 1'b0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    r = model(o, x, y);
    r.acc_cyc = cyc;
    if (got) sb.push_back(r);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: sample at the falling edge, pop when the consumer accepts
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("orphan_result", 64'd1, 64'd0);
        end else begin
          e = sb[0];
          // Non-MUL: visible after the accepting edge. MUL: WIDTH BUSY cycles more.
          if (!prev_valid || prev_pop)
            chk(e.mul ? "latency_mul" : "latency", 64'(cyc - e.acc_cyc), e.mul ? 64'(W + 1) : 64'd1);
          chk("result", 64'(result), 64'(e.res));
          chk("flags", 64'({zero_f, neg_f, carry_f, ovf_f}), 64'(e.flags));
          if (!out_ready) chk("in_ready_hold", 64'(in_ready), 64'd0);
          if (out_ready) void'(sb.pop_front());
        end
      end else if (MUL_EN && sb.size() > 0 && sb[0].mul && cyc > sb[0].acc_cyc) begin
        chk("busy_mul", 64'({busy, in_ready}), 64'b10);
      end
      prev_valid = out_valid;
      prev_pop   = out_valid && out_ready;
    end
  end

  logic [W-1:0] ra, rb;
  int           t0;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 4'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({out_valid, zero_f, neg_f, carry_f, ovf_f, busy}), 64'b010000);
    chk("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases
    send(4'd0,  32'hFFFF_FFFF, 32'h0000_0001);
    send(4'd0,  32'h7FFF_FFFF, 32'h0000_0001);
    send(4'd1,  32'h8000_0000, 32'h0000_0001);
    send(4'd1,  32'h0000_0001, 32'h0000_0002);
    send(4'd5,  32'hFFFF_FFFF, 32'h0000_0001);
    send(4'd9,  32'hFFFF_FFFF, 32'h0000_0001);
    send(4'd8,  32'h8000_0000, 32'h0000_0024);
    send(4'd7,  32'h8000_0000, 32'h0000_0024);
    send(4'd6,  32'h0000_0003, 32'hFFFF_FFE1);
    send(4'd2,  32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd3,  32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd4,  32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd11, 32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
    send(4'd10, 32'h0001_2345, 32'h0000_6789);
    send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Random mix across all opcodes
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      send(4'($urandom_range(0, 15)), ra, rb);
    end

    // Backpressure: result must hold while the consumer stalls
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'd1, 32'h0000_0005, 32'h0000_0009);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_in_ready", 64'(in_ready), 64'd0);

    // Release and issue four ADDs back to back: one per clock
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) send(4'd0, 32'(i * 3 + 1), 32'(100 + i));
    chk("back_to_back_cycles", 64'(cyc - t0), 64'd4);

    // Asynchronous reset in the middle of a multiply
    repeat (2) @(posedge clk);
    #1;
    send(4'd10, 32'h0000_BEEF, 32'h0000_CAFE);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({out_valid, zero_f, neg_f, carry_f, ovf_f, busy}), 64'b010000);
    chk("midrst_result", 64'(result), 64'd0);
    sb.delete();
    prev_valid = 1'b0;
    prev_pop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'd0, 32'd2, 32'd3);

    // Drain the scoreboard within a bounded time
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
